// File: rtl/mcu_bridge_pkg.sv
// Shared types and default geometry for the MCU-to-FPGA register bridge.
package mcu_bridge_pkg;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_ADDR_W      = 5;
  localparam int DEF_NUM_CH      = 17;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } bridge_state_t;

endpackage

// File: rtl/mcu_fpga_regbridge_if.sv
// MCU handshake bundle: request, direction, address and acknowledge.
interface mcu_fpga_regbridge_if #(
  parameter int ADDR_W = mcu_bridge_pkg::DEF_ADDR_W
);
  logic              mcu_mstr;
  logic              write_enable;
  logic [ADDR_W-1:0] address;
  logic              fpga_ack;

  modport master (output mcu_mstr, output write_enable, output address, input fpga_ack);
  modport slave  (input mcu_mstr, input write_enable, input address, output fpga_ack);
endinterface

// File: rtl/mcu_bridge_sync.sv
// Multi-flop single-bit synchroniser; output is 0 while in reset.
module mcu_bridge_sync #(
  parameter int SYNC_STAGES = mcu_bridge_pkg::DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mcu_fpga_regbridge.sv
// MCU register bridge: four-phase handshake onto an output bank / input snapshot.
// Optional input-change interrupt enabled by defining MCU_BRIDGE_IRQ_EN.
module mcu_fpga_regbridge
  import mcu_bridge_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                            CLK50,
  input  logic                            rst_n,
  mcu_fpga_regbridge_if.slave             bus,
  // The data pins stay a plain inout so the tristate resolves at the pad.
  inout  wire  [DATA_W-1:0]               data,
  input  logic [NUM_CH-1:0][DATA_W-1:0]   input_pins_state,
  output logic [NUM_CH-1:0][DATA_W-1:0]   output_pins_state,
  output logic                            wr_stb,
  output logic [ADDR_W-1:0]               wr_idx,
  output logic                            irq
);

  localparam logic [ADDR_W:0] NUM_CH_L = (ADDR_W+1)'(NUM_CH);

  bridge_state_t                  state_q, state_d;
  logic                           ack_q, ack_d;
  logic                           rd_oe_q, rd_oe_d;
  logic                           we_q, we_d;
  logic [DATA_W-1:0]              rd_reg_q, rd_reg_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  out_q, out_d;
  logic                           wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]              wr_idx_q, wr_idx_d;
  logic                           mstr_s;
  logic                           in_range;
  logic                           start;

  mcu_bridge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mstr_sync (
    .clk   (CLK50),
    .rst_n (rst_n),
    .d     (bus.mcu_mstr),
    .q     (mstr_s)
  );

  assign in_range = {1'b0, bus.address} < NUM_CH_L;
  // A level (not edge) check in IDLE cannot miss a request raised during RELEASE.
  assign start    = (state_q == IDLE) && mstr_s;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    rd_oe_d  = rd_oe_q;
    we_d     = we_q;
    rd_reg_d = rd_reg_q;
    out_d    = out_q;
    wr_stb_d = 1'b0;
    wr_idx_d = wr_idx_q;
    unique case (state_q)
      IDLE: begin
        if (mstr_s) begin
          state_d = CAPTURE;
          we_d    = bus.write_enable;
          if (bus.write_enable) begin
            if (in_range) begin
              out_d[bus.address] = data;
              wr_stb_d           = 1'b1;
              wr_idx_d           = bus.address;
            end
          end else begin
            rd_reg_d = in_range ? input_pins_state[bus.address] : '0;
          end
        end
      end
      CAPTURE: begin
        state_d = ACK;
        ack_d   = 1'b1;
        rd_oe_d = !we_q;
      end
      ACK: begin
        if (!mstr_s) begin
          state_d = RELEASE;
          ack_d   = 1'b0;
          rd_oe_d = 1'b0;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the output bank is state visible to the pins, so it is reset like any control flop.
  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      rd_oe_q  <= 1'b0;
      we_q     <= 1'b0;
      rd_reg_q <= '0;
      out_q    <= '0;
      wr_stb_q <= 1'b0;
      wr_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      rd_oe_q  <= rd_oe_d;
      we_q     <= we_d;
      rd_reg_q <= rd_reg_d;
      out_q    <= out_d;
      wr_stb_q <= wr_stb_d;
      wr_idx_q <= wr_idx_d;
    end
  end

  assign bus.fpga_ack      = ack_q;
  assign data              = rd_oe_q ? rd_reg_q : 'z;
  assign output_pins_state = out_q;
  assign wr_stb            = wr_stb_q;
  assign wr_idx            = wr_idx_q;

`ifdef MCU_BRIDGE_IRQ_EN
  logic [NUM_CH-1:0][DATA_W-1:0] hist_q;
  logic [NUM_CH-1:0]             flag_q, flag_d, clr;
  logic                          irq_q, irq_d;

  // A change on the clearing cycle wins, so no edge between reads is lost.
  always_comb begin
    clr    = '0;
    flag_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      clr[i]    = start && !bus.write_enable && (bus.address == ADDR_W'(i));
      flag_d[i] = (input_pins_state[i] != hist_q[i]) || (flag_q[i] && !clr[i]);
    end
    irq_d = |flag_d;
  end

  always_ff @(posedge CLK50 or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      flag_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      hist_q <= input_pins_state;
      flag_q <= flag_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mcu_fpga_regbridge.sv
// Scoreboard bench for mcu_fpga_regbridge: MCU-side handshake tasks plus a wr_stb monitor.
module tb_mcu_fpga_regbridge;
  import mcu_bridge_pkg::*;

  localparam int DATA_W  = DEF_DATA_W;
  localparam int ADDR_W  = DEF_ADDR_W;
  localparam int NUM_CH  = DEF_NUM_CH;
  localparam int S       = DEF_SYNC_STAGES;
  localparam int TIMEOUT = 64;
  localparam logic [DATA_W-1:0] RELEASED = {DATA_W{1'b1}};

  logic                          CLK50 = 1'b0;
  logic                          rst_n;
  logic                          drv_en;
  logic [DATA_W-1:0]             drv_val;
  wire  [DATA_W-1:0]             data;
  logic [NUM_CH-1:0][DATA_W-1:0] in_state;
  logic [NUM_CH-1:0][DATA_W-1:0] output_pins_state;
  logic [NUM_CH-1:0][DATA_W-1:0] exp_out;
  logic                          wr_stb;
  logic [ADDR_W-1:0]             wr_idx;
  logic                          irq;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] exp_rd_q[$];
  logic [ADDR_W-1:0] exp_wr_q[$];

  mcu_fpga_regbridge_if #(.ADDR_W(ADDR_W)) bus ();

  assign data = drv_en ? drv_val : 'z;
  for (genvar g = 0; g < DATA_W; g++) begin : g_pu
    pullup (data[g]);
  end

  mcu_fpga_regbridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .SYNC_STAGES(S)
  ) dut (
    .CLK50             (CLK50),
    .rst_n             (rst_n),
    .bus               (bus),
    .data              (data),
    .input_pins_state  (in_state),
    .output_pins_state (output_pins_state),
    .wr_stb            (wr_stb),
    .wr_idx            (wr_idx),
    .irq               (irq)
  );

  always #5 CLK50 = ~CLK50;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every wr_stb must match a queued in-range write, one pulse each.
  always @(negedge CLK50) begin
    if (rst_n && wr_stb) begin
      if (exp_wr_q.size() == 0) check("wr_stb_spurious", 1, 0);
      else                      check("wr_idx", wr_idx, exp_wr_q.pop_front());
    end
  end

  task automatic wait_ack(input logic lvl, input int exp_n, input string tag);
    int n = 0;
    do begin
      @(negedge CLK50);
      n++;
    end while (bus.fpga_ack !== lvl && n < TIMEOUT);
    check(tag, n, exp_n);
  endtask

  // Full MCU transaction; tog_ch >= 0 changes that input on the cycle before CAPTURE's edge.
  task automatic mcu_xact(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                          input int tog_ch, input logic [DATA_W-1:0] tog_val);
    int n = 0;
    bus.write_enable = we;
    bus.address      = a;
    drv_val          = wd;
    drv_en           = we;
    if (we) begin
      if (int'(a) < NUM_CH) begin
        exp_out[a] = wd;
        exp_wr_q.push_back(a);
      end
    end else if (tog_ch >= 0 && tog_ch == int'(a)) begin
      exp_rd_q.push_back(tog_val);
    end else begin
      exp_rd_q.push_back(int'(a) < NUM_CH ? in_state[a] : '0);
    end
    bus.mcu_mstr = 1'b1;
    do begin
      @(negedge CLK50);
      n++;
      if (n == S && tog_ch >= 0) in_state[tog_ch] = tog_val;
      if (n == S + 1 && !we) check("rd_released_capture", data, RELEASED);
    end while (!bus.fpga_ack && n < TIMEOUT);
    check("ack_rise_lat", n, S + 2);
    if (!we) check("rd_data", data, exp_rd_q.pop_front());
    bus.mcu_mstr = 1'b0;
    drv_en       = 1'b0;
    wait_ack(1'b0, S + 1, "ack_fall_lat");
    check("data_released_after", data, RELEASED);
    check("out_bank", output_pins_state, exp_out);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.mcu_mstr     = 1'b0;
    bus.write_enable = 1'b0;
    bus.address      = '0;
    drv_en           = 1'b0;
    drv_val          = '0;
    in_state         = '0;
    exp_out          = '0;
    repeat (2) @(negedge CLK50);
    check("rst_ack", bus.fpga_ack, 0);
    check("rst_data", data, RELEASED);
    check("rst_out", output_pins_state, 0);
    check("rst_wr_stb", wr_stb, 0);
    check("rst_wr_idx", wr_idx, 0);
    check("rst_irq", irq, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge CLK50);

    mcu_xact(1'b1, 5'd3, 8'hA5, -1, '0);
    in_state[16] = 8'h3C;
    mcu_xact(1'b0, 5'd16, '0, -1, '0);
    mcu_xact(1'b1, 5'd20, 8'h77, -1, '0);
    mcu_xact(1'b0, 5'd20, '0, -1, '0);
    mcu_xact(1'b1, 5'd0, 8'h01, -1, '0);

    // One-cycle request: must yield exactly one write and a short ack.
    bus.write_enable = 1'b1;
    bus.address      = 5'd7;
    drv_val          = 8'h5A;
    drv_en           = 1'b1;
    exp_out[7]       = 8'h5A;
    exp_wr_q.push_back(5'd7);
    bus.mcu_mstr     = 1'b1;
    @(negedge CLK50);
    bus.mcu_mstr     = 1'b0;
    wait_ack(1'b1, S + 1, "pulse_ack_rise_lat");
    drv_en = 1'b0;
    wait_ack(1'b0, 1, "pulse_ack_width");
    repeat (6) @(negedge CLK50);
    check("pulse_out_bank", output_pins_state, exp_out);
    check("pulse_wr_pending", exp_wr_q.size(), 0);

`ifdef MCU_BRIDGE_IRQ_EN
    in_state[5] = 8'h11;
    repeat (2) @(negedge CLK50);
    check("irq_set", irq, 1);
    mcu_xact(1'b0, 5'd5, '0, -1, '0);
    check("irq_cleared", irq, 0);
    mcu_xact(1'b0, 5'd5, '0, 5, 8'h22);
    check("irq_change_wins", irq, 1);
`else
    in_state[5] = 8'h11;
    repeat (2) @(negedge CLK50);
    check("irq_tied", irq, 0);
    mcu_xact(1'b0, 5'd5, '0, 5, 8'h22);
    check("irq_tied_after", irq, 0);
`endif

    // Reset while a read is being acknowledged.
    bus.write_enable = 1'b0;
    bus.address      = 5'd16;
    bus.mcu_mstr     = 1'b1;
    wait_ack(1'b1, S + 2, "rst_case_ack_rise_lat");
    check("rst_case_rd_data", data, in_state[16]);
    rst_n        = 1'b0;
    bus.mcu_mstr = 1'b0;
    #1;
    exp_out = '0;
    check("midrst_ack", bus.fpga_ack, 0);
    check("midrst_data", data, RELEASED);
    check("midrst_out", output_pins_state, exp_out);
    check("midrst_irq", irq, 0);
    @(negedge CLK50);
    rst_n = 1'b1;
    repeat (2) @(negedge CLK50);
    mcu_xact(1'b1, 5'd3, 8'h5C, -1, '0);
    mcu_xact(1'b0, 5'd16, '0, -1, '0);

    repeat (4) @(negedge CLK50);
    check("wr_queue_empty", exp_wr_q.size(), 0);
    check("rd_queue_empty", exp_rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcu_fpga_regbridge.md
# mcu_fpga_regbridge

Parametrised MCU-to-FPGA register bridge replacing the fixed 8-bit/17-channel bus slave. An external MCU runs a four-phase request/acknowledge handshake over an asynchronous parallel bus. The block synchronises the request, captures address, direction and data, and then either updates an output-channel register bank or returns a snapshot of an input channel on a tristated data bus. It sits between the MCU pin interface and the pin-state logic of the cell.

## Interface
- DATA_W, 8: data bus and channel width
- ADDR_W, 5: address width
- NUM_CH, 17: number of input and output channels (≤ 2**ADDR_W)
- SYNC_STAGES, 2: flops in the mcu_mstr synchroniser (≥ 2)

- CLK50  in  1  system clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- mcu_mstr  in  1  MCU request, asynchronous to CLK50
- write_enable  in  1  1 = write, 0 = read; stable while mcu_mstr high
- address  in  ADDR_W  channel index; stable while mcu_mstr high
- data  inout  DATA_W  bidirectional bus; FPGA drives only during read response, else 'z
- fpga_ack  out  1  handshake acknowledge
- input_pins_state  in  DATA_W × NUM_CH  input channel values
- output_pins_state  out  DATA_W × NUM_CH  registered output channels
- wr_stb  out  1  one-cycle pulse on every accepted write
- wr_idx  out  ADDR_W  index of the channel written, valid with wr_stb
- irq  out  1  input-change interrupt (MCU_BRIDGE_IRQ_EN only; tied 0 otherwise)

## Operation
- FSM states: IDLE, CAPTURE, ACK, RELEASE.
- IDLE: fpga_ack=0, data released. Rising synchronised mcu_mstr → CAPTURE.
- CAPTURE, one cycle:
  - register address, write_enable and data.
  - write to address < NUM_CH: update output_pins_state[address]; wr_stb=1; wr_idx=address.
  - write to address ≥ NUM_CH: dropped; no wr_stb.
  - read: latch input_pins_state[address] into rd_reg; out-of-range address returns 0.
  - → ACK.
- ACK: fpga_ack=1. Read: data driven with rd_reg. Synchronised mcu_mstr low → RELEASE.
- RELEASE, one cycle: fpga_ack=0, data released → IDLE. A new request is recognised only from IDLE.
- MCU protocol: set address, write_enable and data (write); raise mcu_mstr; wait fpga_ack=1; read data; drop mcu_mstr; wait fpga_ack=0.
- Early drop: if mcu_mstr falls during CAPTURE, the transaction still completes. ACK is held at least one cycle, then RELEASE.
- Reset, including mid-transaction: state=IDLE, fpga_ack=0, data='z, output_pins_state all 0, wr_stb=0, wr_idx=0, rd_reg=0, irq=0, change flags cleared.

## Timing
- mcu_mstr rise → first synchronised high: SYNC_STAGES cycles.
- The CAPTURE edge follows the synchronised rise. fpga_ack rises on the following edge: SYNC_STAGES+2 cycles after mcu_mstr is first sampled high.
- Output register update and wr_stb occur on the CAPTURE edge, one cycle before fpga_ack rises.
- Read data is valid on the bus from the fpga_ack rising edge until the fpga_ack falling edge.
- mcu_mstr fall → fpga_ack fall: SYNC_STAGES+1 cycles.
- address, write_enable and data are sampled only at CAPTURE, after synchronisation, so they need no synchroniser. The MCU holds them from the mcu_mstr rise until fpga_ack=1.

## Configuration
- MCU_BRIDGE_IRQ_EN defined:
  - per-channel change flag set when input_pins_state[i] differs from its previous-cycle value.
  - irq = OR of all flags, registered.
  - a read of channel i in CAPTURE clears flag i. A change on the same cycle as the clear wins and leaves the flag set.
- MCU_BRIDGE_IRQ_EN undefined: no flags and no history registers; irq constant 0.

## Structure
- Package mcu_bridge_pkg holds:
  - the state enum (bridge_state_t: IDLE, CAPTURE, ACK, RELEASE).
  - default DATA_W, ADDR_W, NUM_CH and SYNC_STAGES constants.
- One sub-module, mcu_bridge_sync: SYNC_STAGES-deep single-bit synchroniser with async active-low reset to 0. Used for mcu_mstr.

## Test plan
- Write 8'hA5 to address 3 → wr_stb pulse with wr_idx=3; output_pins_state[3]=8'hA5, others 0; fpga_ack rises at SYNC_STAGES+2 and falls SYNC_STAGES+1 after mcu_mstr drops.
- input_pins_state[16]=8'h3C, read address 16 → data=8'h3C while fpga_ack=1; 'z before and after.
- Write address 20 (≥ NUM_CH) → no wr_stb, outputs unchanged, handshake completes. Read address 20 → data=8'h00.
- Assert rst_n=0 during ACK of a read → fpga_ack=0 and data='z immediately; outputs 0. A transaction after release completes normally.
- mcu_mstr high for 1 cycle only → exactly one transaction. fpga_ack high ≥1 cycle, then low; no second wr_stb.
- MCU_BRIDGE_IRQ_EN: toggle input_pins_state[5] → irq=1. Read address 5 → irq=0 after CAPTURE. Toggle on the CAPTURE cycle → irq stays 1.
